// File: rtl/input_debouncer.sv
// Debouncer for an asynchronous level input: synchronizer chain, mismatch
// counter FSM, registered level output with one-cycle rise/fall pulses.
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    input  logic enable,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value on the edge before the one that accepts the new level
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE,
        COUNT
    } state_t;

    state_t            state, state_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic              dout_next;
    logic [SYNC_STAGES-1:0] sync;
    logic              s;

    assign s    = sync[SYNC_STAGES-1];
    assign busy = (state == COUNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= STABLE;
            cnt   <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            dout  <= dout_next;
            rise  <= dout_next & ~dout;
            fall  <= ~dout_next & dout;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dout_next  = dout;
        if (!enable) begin
            state_next = STABLE;
            cnt_next   = '0;
        end else begin
            case (state)
                STABLE: begin
                    if (s != dout) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            dout_next = s;
                        end else begin
                            state_next = COUNT;
                            cnt_next   = CW'(1);
                        end
                    end
                end
                COUNT: begin
                    if (s == dout) begin
                        state_next = STABLE;
                        cnt_next   = '0;
                    end else if (cnt == CNT_LAST) begin
                        dout_next  = s;
                        state_next = STABLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                default: begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer at default parameters; outputs are
// sampled 1 time unit after each rising edge as {dout, rise, fall, busy}.
module tb_input_debouncer;

    logic clk;
    logic reset_n;
    logic din;
    logic enable;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    int unsigned n_checks;
    int unsigned n_fails;

    input_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (din),
        .enable (enable),
        .dout   (dout),
        .rise   (rise),
        .fall   (fall),
        .busy   (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {dout,rise,fall,busy} after edges 1..N of each scenario
    logic [3:0] exp_rise [8]  = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                                  4'b0001, 4'b1100, 4'b1000, 4'b1000};
    logic [3:0] exp_fall [8]  = '{4'b1000, 4'b1000, 4'b1001, 4'b1001,
                                  4'b1001, 4'b0010, 4'b0000, 4'b0000};
    logic [3:0] exp_short [9] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                                  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] exp_en [10]   = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                                  4'b0000, 4'b0001, 4'b0001, 4'b0001,
                                  4'b1100, 4'b1000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int unsigned step, input logic [3:0] expv);
        logic [3:0] obs;
        obs = {dout, rise, fall, busy};
        n_checks++;
        assert (obs === expv)
        else begin
            n_fails++;
            $error("FAIL %s step %0d: {dout,rise,fall,busy} observed=%b expected=%b",
                   tag, step, obs, expv);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset_n  = 1'b0;
        din      = 1'b0;
        enable   = 1'b1;

        // Reset state, then 10 idle cycles with din=0
        #12;
        check("reset_hold", 0, 4'b0000);
        tick();
        reset_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("idle_after_reset", i, 4'b0000);
        end

        // din 0->1 held: busy from edge 3, dout/rise after edge 6
        din = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rise_latency", i + 1, exp_rise[i]);
        end

        // din 1->0 held: fall pulse after edge 6
        din = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("fall_latency", i + 1, exp_fall[i]);
        end

        // din high for 3 cycles only: rejected as a glitch
        din = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 2) din = 1'b0;
            check("short_pulse", i + 1, exp_short[i]);
        end

        // enable dropped for the edge after count reaches 2
        din = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 3) enable = 1'b0;
            if (i == 4) enable = 1'b1;
            check("enable_drop", i + 1, exp_en[i]);
        end

        // Return dout to 0
        din = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("fall_again", i + 1, exp_fall[i]);
        end

        // Reset asserted mid-count (count=3) with din=1
        din = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("pre_reset_count", i + 1, exp_rise[i]);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_clear", 0, 4'b0000);
        tick();
        check("reset_across_edge", 1, 4'b0000);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_reset_rise", i + 1, exp_rise[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
